// File: rtl/fluxo_dados_genius_param.sv
// rtl/fluxo_dados_genius_param.sv - parametrised datapath for the memory-sequence game
module fluxo_dados_genius_param #(
    parameter int NB        = 4,
    parameter int AW        = 4,
    parameter int TIMEOUT_M = 5000,
    parameter int TMR_M     = 500
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [NB-1:0] botoes,
    input  logic          zeraE,
    input  logic          contaE,
    input  logic          zeraL,
    input  logic          contaL,
    input  logic          zeraR,
    input  logic          registraR,
    input  logic          zeraM,
    input  logic          registraM,
    input  logic          escreveM,
    input  logic          zeraTMR,
    input  logic          contaTMR,
    input  logic          zeraTO,
    output logic          fimE,
    output logic          fimL,
    output logic          fimTMR,
    output logic          jogada_feita,
    output logic          jogada_valida,
    output logic          chavesIgualMemoria,
    output logic          enderecoIgualSequencia,
    output logic          enderecoMenorOuIgualSequencia,
    output logic          timeout,
    output logic          db_tem_jogada,
    output logic [AW-1:0] db_contagem,
    output logic [AW-1:0] db_sequencia,
    output logic [NB-1:0] db_jogada,
    output logic [NB-1:0] db_memoria
);

    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(TIMEOUT_M);
    localparam int MW    = $clog2(TMR_M);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_M - 1);
    localparam logic [MW-1:0] TMR_LAST = MW'(TMR_M - 1);

    logic [AW-1:0] r_cnt_e;
    logic [AW-1:0] r_cnt_l;
    logic [NB-1:0] r_jogada;
    logic [NB-1:0] r_mem_out;
    logic [NB-1:0] r_rd_data;
    logic [NB-1:0] r_ram [DEPTH];
    logic          r_tem_d;
    logic          r_jogada_feita;
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;
    logic [MW-1:0] r_tmr;

    logic          w_tem_jogada;
    logic          w_to_clear;

    assign w_tem_jogada = |botoes;
    assign w_to_clear   = zeraTO | zeraE | contaE | r_jogada_feita;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt_e <= '0;
            r_cnt_l <= '0;
        end else begin
            if (zeraE)       r_cnt_e <= '0;
            else if (contaE) r_cnt_e <= r_cnt_e + AW'(1);
            if (zeraL)       r_cnt_l <= '0;
            else if (contaL) r_cnt_l <= r_cnt_l + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_jogada  <= '0;
            r_mem_out <= '0;
        end else begin
            if (zeraR)          r_jogada  <= '0;
            else if (registraR) r_jogada  <= botoes;
            if (zeraM)          r_mem_out <= '0;
            else if (registraM) r_mem_out <= r_rd_data;
        end
    end

    // Memory and its read register are deliberately outside reset so the
    // stored sequence survives a game restart; same-address writes forward.
    always_ff @(posedge clock) begin
        if (escreveM) begin
            r_ram[r_cnt_e] <= r_jogada;
            r_rd_data      <= r_jogada;
        end else begin
            r_rd_data      <= r_ram[r_cnt_e];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tem_d        <= 1'b0;
            r_jogada_feita <= 1'b0;
        end else begin
            r_tem_d        <= w_tem_jogada;
            r_jogada_feita <= w_tem_jogada & ~r_tem_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_to_clear) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (!w_tem_jogada && !r_timeout) begin
            if (r_to_cnt == TO_LAST) r_timeout <= 1'b1;
            else                     r_to_cnt  <= r_to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)                r_tmr <= '0;
        else if (zeraTMR)          r_tmr <= '0;
        else if (contaTMR) begin
            if (r_tmr == TMR_LAST) r_tmr <= '0;
            else                   r_tmr <= r_tmr + MW'(1);
        end
    end

    assign fimE                          = (r_cnt_e == {AW{1'b1}});
    assign fimL                          = (r_cnt_l == {AW{1'b1}});
    assign fimTMR                        = (r_tmr == TMR_LAST);
    assign jogada_feita                  = r_jogada_feita;
    assign jogada_valida                 = (r_jogada != '0) && ((r_jogada & (r_jogada - NB'(1))) == '0);
    assign chavesIgualMemoria            = (r_jogada == r_rd_data);
    assign enderecoIgualSequencia        = (r_cnt_e == r_cnt_l);
    assign enderecoMenorOuIgualSequencia = (r_cnt_e <= r_cnt_l);
    assign timeout                       = r_timeout;
    assign db_tem_jogada                 = w_tem_jogada;
    assign db_contagem                   = r_cnt_e;
    assign db_sequencia                  = r_cnt_l;
    assign db_jogada                     = r_jogada;
    assign db_memoria                    = r_mem_out;

endmodule

// File: tb/tb_fluxo_dados_genius_param.sv
// tb/tb_fluxo_dados_genius_param.sv - directed and random checks against a behavioural model
module tb_fluxo_dados_genius_param;

    localparam int NB    = 4;
    localparam int AW    = 4;
    localparam int TO_M  = 8;
    localparam int TMR_M = 4;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] botoes;
    logic zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraM, registraM;
    logic escreveM, zeraTMR, contaTMR, zeraTO;
    logic fimE, fimL, fimTMR, jogada_feita, jogada_valida, chavesIgualMemoria;
    logic enderecoIgualSequencia, enderecoMenorOuIgualSequencia, timeout, db_tem_jogada;
    logic [AW-1:0] db_contagem, db_sequencia;
    logic [NB-1:0] db_jogada, db_memoria;

    fluxo_dados_genius_param #(.NB(NB), .AW(AW), .TIMEOUT_M(TO_M), .TMR_M(TMR_M)) dut (
        .clock(clock), .reset(reset), .botoes(botoes),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .zeraM(zeraM), .registraM(registraM),
        .escreveM(escreveM), .zeraTMR(zeraTMR), .contaTMR(contaTMR), .zeraTO(zeraTO),
        .fimE(fimE), .fimL(fimL), .fimTMR(fimTMR), .jogada_feita(jogada_feita),
        .jogada_valida(jogada_valida), .chavesIgualMemoria(chavesIgualMemoria),
        .enderecoIgualSequencia(enderecoIgualSequencia),
        .enderecoMenorOuIgualSequencia(enderecoMenorOuIgualSequencia),
        .timeout(timeout), .db_tem_jogada(db_tem_jogada),
        .db_contagem(db_contagem), .db_sequencia(db_sequencia),
        .db_jogada(db_jogada), .db_memoria(db_memoria)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference state: game-level quantities, not register images.
    int m_addr, m_len, m_jog, m_memreg, m_rd, m_tmr, m_idle;
    bit m_rd_ok, m_prev_press, m_pulse;
    int m_mem [DEPTH];
    bit m_mem_ok [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraM, registraM} = '0;
        {escreveM, zeraTMR, contaTMR, zeraTO} = '0;
        reset = 1'b1;
    endtask

    task automatic check_all();
        chk("fimE", fimE, m_addr == DEPTH - 1);
        chk("fimL", fimL, m_len == DEPTH - 1);
        chk("fimTMR", fimTMR, m_tmr == TMR_M - 1);
        chk("jogada_feita", jogada_feita, m_pulse);
        chk("jogada_valida", jogada_valida, $countones(m_jog) == 1);
        if (m_rd_ok) chk("chavesIgualMemoria", chavesIgualMemoria, m_jog == m_rd);
        chk("enderecoIgual", enderecoIgualSequencia, m_addr == m_len);
        chk("enderecoMenorIgual", enderecoMenorOuIgualSequencia, m_addr <= m_len);
        chk("timeout", timeout, m_idle >= TO_M);
        chk("db_tem_jogada", db_tem_jogada, botoes != 0);
        chk("db_contagem", db_contagem, m_addr);
        chk("db_sequencia", db_sequencia, m_len);
        chk("db_jogada", db_jogada, m_jog);
        chk("db_memoria", db_memoria, m_memreg);
    endtask

    task automatic tick();
        int  n_rd;
        bit  n_ok;
        bit  press;
        @(posedge clock);
        press = (botoes != 0);
        if (escreveM) begin
            m_mem[m_addr] = m_jog;
            m_mem_ok[m_addr] = 1'b1;
            n_rd = m_jog;
            n_ok = 1'b1;
        end else begin
            n_rd = m_mem[m_addr];
            n_ok = m_mem_ok[m_addr];
        end
        if (!reset) begin
            m_addr = 0; m_len = 0; m_jog = 0; m_memreg = 0; m_tmr = 0; m_idle = 0;
            m_prev_press = 0; m_pulse = 0;
        end else begin
            if (zeraTO || zeraE || contaE || m_pulse) m_idle = 0;
            else if (!press && m_idle < TO_M)         m_idle++;
            m_addr   = zeraE ? 0 : contaE ? (m_addr + 1) % DEPTH : m_addr;
            m_len    = zeraL ? 0 : contaL ? (m_len + 1) % DEPTH : m_len;
            m_jog    = zeraR ? 0 : registraR ? int'(botoes) : m_jog;
            m_memreg = zeraM ? 0 : registraM ? m_rd : m_memreg;
            m_tmr    = zeraTMR ? 0 : contaTMR ? (m_tmr + 1) % TMR_M : m_tmr;
            m_pulse  = press && !m_prev_press;
            m_prev_press = press;
        end
        m_rd = n_rd;
        m_rd_ok = n_ok;
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int pulses;
    int first_pulse;
    int fims;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_mem_ok[i] = 0; end
        m_rd = 0; m_rd_ok = 0;
        idle_inputs();
        botoes = '0;
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        chk("reset_db_contagem", db_contagem, 0);
        chk("reset_timeout", timeout, 0);
        chk("reset_valida", jogada_valida, 0);

        // write 0010 at address 0, then read it back
        botoes = 4'b0010; registraR = 1; tick();
        idle_inputs(); botoes = '0; escreveM = 1; tick();
        idle_inputs(); contaE = 1; tick();
        idle_inputs(); zeraE = 1; tick();
        idle_inputs(); tick();
        registraM = 1; tick();
        idle_inputs();
        chk("rw_db_memoria", db_memoria, 4'b0010);
        chk("rw_chaves", chavesIgualMemoria, 1);

        // single pulse on a held press
        ticks(2);
        botoes = 4'b0100;
        pulses = 0; first_pulse = -1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (jogada_feita) begin pulses++; if (first_pulse < 0) first_pulse = i; end
        end
        chk("edge_pulse_count", pulses, 1);
        chk("edge_pulse_pos", first_pulse, 0);
        botoes = 4'b0110; registraR = 1; tick();
        idle_inputs(); botoes = '0;
        chk("two_bits_invalid", jogada_valida, 0);
        ticks(2);

        // timeout assertion, hold and clear by press
        zeraTO = 1; tick(); idle_inputs();
        ticks(TO_M - 1);
        chk("timeout_before", timeout, 0);
        tick();
        chk("timeout_reached", timeout, 1);
        ticks(3);
        chk("timeout_holds", timeout, 1);
        botoes = 4'b0001; tick();
        botoes = '0; tick();
        chk("timeout_cleared_by_press", timeout, 0);
        zeraTO = 1; tick(); idle_inputs();
        ticks(TO_M - 1);
        contaE = 1; tick(); idle_inputs();
        chk("timeout_contaE_wins", timeout, 0);
        ticks(TO_M - 1);
        chk("timeout_restarted", timeout, 0);

        // address vs sequence-length compares
        zeraE = 1; zeraL = 1; tick(); idle_inputs();
        contaL = 1; ticks(3); idle_inputs();
        for (int a = 0; a <= 4; a++) begin
            chk("cmp_le", enderecoMenorOuIgualSequencia, a <= 3);
            chk("cmp_eq", enderecoIgualSequencia, a == 3);
            contaE = 1; tick(); idle_inputs();
        end

        // address wrap
        zeraE = 1; tick(); idle_inputs();
        contaE = 1; ticks(DEPTH - 1);
        chk("wrap_fimE", fimE, 1);
        chk("wrap_addr15", db_contagem, DEPTH - 1);
        tick(); idle_inputs();
        chk("wrap_addr0", db_contagem, 0);

        // reset in the middle of a game
        botoes = 4'b1000; registraR = 1; tick(); idle_inputs(); botoes = '0;
        ticks(2);
        zeraE = 1; tick(); idle_inputs();
        contaE = 1; ticks(5); idle_inputs();
        ticks(TO_M + 1);
        chk("mid_addr", db_contagem, 5);
        chk("mid_timeout", timeout, 1);
        chk("mid_jogada", db_jogada, 4'b1000);
        reset = 1'b0; tick(); reset = 1'b1;
        chk("post_reset_addr", db_contagem, 0);
        chk("post_reset_timeout", timeout, 0);
        chk("post_reset_jogada", db_jogada, 0);
        tick();
        registraM = 1; tick(); idle_inputs();
        chk("ram_persists", db_memoria, 4'b0010);

        // display timer
        zeraTMR = 1; tick(); idle_inputs();
        contaTMR = 1; fims = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (fimTMR) fims++; end
        chk("tmr_fim_count", fims, 2);
        ticks(1);
        zeraTMR = 1; tick(); zeraTMR = 0;
        chk("tmr_zera_wins", fimTMR, 0);
        ticks(3);
        chk("tmr_after_zera", fimTMR, 1);
        idle_inputs();

        // randomized operation
        for (int i = 0; i < 400; i++) begin
            botoes    = ($urandom_range(0, 3) == 0) ? NB'($urandom) : botoes;
            zeraE     = ($urandom_range(0, 15) == 0);
            contaE    = ($urandom_range(0, 3) == 0);
            zeraL     = ($urandom_range(0, 15) == 0);
            contaL    = ($urandom_range(0, 5) == 0);
            zeraR     = ($urandom_range(0, 15) == 0);
            registraR = ($urandom_range(0, 3) == 0);
            zeraM     = ($urandom_range(0, 15) == 0);
            registraM = ($urandom_range(0, 3) == 0);
            escreveM  = ($urandom_range(0, 4) == 0);
            zeraTMR   = ($urandom_range(0, 15) == 0);
            contaTMR  = ($urandom_range(0, 1) == 0);
            zeraTO    = ($urandom_range(0, 20) == 0);
            reset     = ($urandom_range(0, 60) != 0);
            tick();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
